// File: rtl/ai_rd_dispatcher.sv
// ai_rd_dispatcher: per-master read-path dispatcher.
// Decodes the AR address to one of SLV_AMT slave ports, forwards the AR there,
// and returns R bursts to the master strictly in AR issue order. An order FIFO
// of slave indices holds up to OUTSTANDING_AMT outstanding reads. When the FIFO
// is full, new ARs are backpressured.
// Optional feature: define AI_DSP_AR_SLICE_EN to insert a one-entry AR register
// slice in front of the slave ports. This adds one cycle of AR latency. The
// order entry is reserved when the slice loads.
module ai_rd_dispatcher #(
    parameter int SLV_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 8,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int SLV_ID_MSB_IDX    = 30,
    parameter int SLV_ID_LSB_IDX    = 30
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESETn_i,
    input  logic [TRANS_MST_ID_W-1:0]              m_ARID_i,
    input  logic [ADDR_WIDTH-1:0]                  m_ARADDR_i,
    input  logic [TRANS_BURST_W-1:0]               m_ARBURST_i,
    input  logic [TRANS_DATA_LEN_W-1:0]            m_ARLEN_i,
    input  logic [TRANS_DATA_SIZE_W-1:0]           m_ARSIZE_i,
    input  logic                                   m_ARVALID_i,
    output logic                                   m_ARREADY_o,
    input  logic                                   m_RREADY_i,
    output logic [TRANS_MST_ID_W-1:0]              m_RID_o,
    output logic [DATA_WIDTH-1:0]                  m_RDATA_o,
    output logic                                   m_RLAST_o,
    output logic                                   m_RVALID_o,
    output logic [SLV_AMT*TRANS_MST_ID_W-1:0]      sa_ARID_o,
    output logic [SLV_AMT*ADDR_WIDTH-1:0]          sa_ARADDR_o,
    output logic [SLV_AMT*TRANS_BURST_W-1:0]       sa_ARBURST_o,
    output logic [SLV_AMT*TRANS_DATA_LEN_W-1:0]    sa_ARLEN_o,
    output logic [SLV_AMT*TRANS_DATA_SIZE_W-1:0]   sa_ARSIZE_o,
    output logic [SLV_AMT-1:0]                     sa_ARVALID_o,
    input  logic [SLV_AMT-1:0]                     sa_ARREADY_i,
    output logic [SLV_AMT-1:0]                     sa_AR_outst_full_o,
    input  logic [SLV_AMT*TRANS_MST_ID_W-1:0]      sa_RID_i,
    input  logic [SLV_AMT*DATA_WIDTH-1:0]          sa_RDATA_i,
    input  logic [SLV_AMT-1:0]                     sa_RLAST_i,
    input  logic [SLV_AMT-1:0]                     sa_RVALID_i,
    output logic [SLV_AMT-1:0]                     sa_RREADY_o
);

    localparam int SEL_W = SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1;
    localparam int IDX_W = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1;
    localparam int PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [SEL_W-1:0] sel_raw;
    logic [IDX_W-1:0] dec_sel;

    logic [IDX_W-1:0] order_mem [OUTSTANDING_AMT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] push_sel;
    logic [IDX_W-1:0] head;

    logic                          ar_vld;
    logic [IDX_W-1:0]              ar_sel;
    logic [TRANS_MST_ID_W-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]         ar_addr;
    logic [TRANS_BURST_W-1:0]      ar_burst;
    logic [TRANS_DATA_LEN_W-1:0]   ar_len;
    logic [TRANS_DATA_SIZE_W-1:0]  ar_size;

    logic [TRANS_MST_ID_W-1:0]     head_rid;
    logic [DATA_WIDTH-1:0]         head_rdata;
    logic                          head_rlast;
    logic                          head_rvalid;
    logic                          r_active;

    assign full  = (cnt == CNT_W'(OUTSTANDING_AMT));
    assign empty = (cnt == '0);

    // Address decode; out-of-range select values fall through to the last slave.
    always_comb begin
        sel_raw = m_ARADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
        if (32'(sel_raw) >= 32'(SLV_AMT))
            dec_sel = IDX_W'(SLV_AMT - 1);
        else
            dec_sel = IDX_W'(sel_raw);
    end

`ifdef AI_DSP_AR_SLICE_EN
    logic slc_vld;
    logic slc_drain;
    logic slc_open;

    assign slc_drain   = slc_vld & sa_ARREADY_i[ar_sel];
    // The order entry is reserved when the slice loads, so a full FIFO blocks the load.
    assign slc_open    = (~slc_vld | slc_drain) & ~full & ARESETn_i;
    assign m_ARREADY_o = slc_open;
    assign push        = m_ARVALID_i & slc_open;
    assign push_sel    = dec_sel;
    assign ar_vld      = slc_vld;

    // One-entry AR slice: load on master handshake, clear when the slave takes it.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            slc_vld  <= 1'b0;
            ar_sel   <= '0;
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_burst <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
        end else if (push) begin
            slc_vld  <= 1'b1;
            ar_sel   <= dec_sel;
            ar_id    <= m_ARID_i;
            ar_addr  <= m_ARADDR_i;
            ar_burst <= m_ARBURST_i;
            ar_len   <= m_ARLEN_i;
            ar_size  <= m_ARSIZE_i;
        end else if (slc_drain) begin
            slc_vld  <= 1'b0;
        end
    end
`else
    assign ar_vld      = m_ARVALID_i & ~full;
    assign ar_sel      = dec_sel;
    assign ar_id       = m_ARID_i;
    assign ar_addr     = m_ARADDR_i;
    assign ar_burst    = m_ARBURST_i;
    assign ar_len      = m_ARLEN_i;
    assign ar_size     = m_ARSIZE_i;
    assign m_ARREADY_o = sa_ARREADY_i[dec_sel] & ~full & ARESETn_i;
    assign push        = m_ARVALID_i & m_ARREADY_o;
    assign push_sel    = dec_sel;
`endif

    assign sa_ARID_o          = {SLV_AMT{ar_id}};
    assign sa_ARADDR_o        = {SLV_AMT{ar_addr}};
    assign sa_ARBURST_o       = {SLV_AMT{ar_burst}};
    assign sa_ARLEN_o         = {SLV_AMT{ar_len}};
    assign sa_ARSIZE_o        = {SLV_AMT{ar_size}};
    assign sa_AR_outst_full_o = {SLV_AMT{full}};

    // One-hot AR valid toward the selected slave; held low during reset.
    always_comb begin
        sa_ARVALID_o = '0;
        for (int s = 0; s < SLV_AMT; s++)
            sa_ARVALID_o[s] = ar_vld & ARESETn_i & (ar_sel == IDX_W'(s));
    end

    assign head = order_mem[rd_ptr];

    // R payload mux from the slave at the head of the order FIFO.
    always_comb begin
        head_rid    = '0;
        head_rdata  = '0;
        head_rlast  = 1'b0;
        head_rvalid = 1'b0;
        for (int s = 0; s < SLV_AMT; s++) begin
            if (head == IDX_W'(s)) begin
                head_rid    = sa_RID_i[s*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                head_rdata  = sa_RDATA_i[s*DATA_WIDTH +: DATA_WIDTH];
                head_rlast  = sa_RLAST_i[s];
                head_rvalid = sa_RVALID_i[s];
            end
        end
    end

    assign r_active   = ~empty & ARESETn_i;
    assign m_RID_o    = head_rid;
    assign m_RDATA_o  = head_rdata;
    assign m_RLAST_o  = head_rlast;
    assign m_RVALID_o = r_active & head_rvalid;
    assign pop        = m_RVALID_o & m_RREADY_i & head_rlast;

    // Only the head slave sees RREADY; all other slaves stall until they reach the head.
    always_comb begin
        sa_RREADY_o = '0;
        for (int s = 0; s < SLV_AMT; s++)
            sa_RREADY_o[s] = r_active & m_RREADY_i & (head == IDX_W'(s));
    end

    // Order FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge ACLK_i) begin
        if (push)
            order_mem[wr_ptr] <= push_sel;
    end

    // Order FIFO pointers and occupancy.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ai_rd_dispatcher.sv
// Testbench for ai_rd_dispatcher in its default build (combinational AR path).
// The reference model is a queue of slave indices in AR issue order.
module tb_ai_rd_dispatcher;

    localparam int SLV = 2;
    localparam int OUTST = 8;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IDW = 5;
    localparam int MSB = 30;
    localparam int LSB = 30;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [IDW-1:0]     m_arid;
    logic [AW-1:0]      m_araddr;
    logic [1:0]         m_arburst;
    logic [7:0]         m_arlen;
    logic [2:0]         m_arsize;
    logic               m_arvalid;
    logic               m_arready;
    logic               m_rready;
    logic [IDW-1:0]     m_rid;
    logic [DW-1:0]      m_rdata;
    logic               m_rlast;
    logic               m_rvalid;
    logic [SLV*IDW-1:0] sa_arid;
    logic [SLV*AW-1:0]  sa_araddr;
    logic [SLV*2-1:0]   sa_arburst;
    logic [SLV*8-1:0]   sa_arlen;
    logic [SLV*3-1:0]   sa_arsize;
    logic [SLV-1:0]     sa_arvalid;
    logic [SLV-1:0]     sa_arready;
    logic [SLV-1:0]     sa_full;
    logic [SLV*IDW-1:0] sa_rid;
    logic [SLV*DW-1:0]  sa_rdata;
    logic [SLV-1:0]     sa_rlast;
    logic [SLV-1:0]     sa_rvalid;
    logic [SLV-1:0]     sa_rready;

    int n_cmp = 0;
    int n_err = 0;
    int oq[$];

    always #5 clk = ~clk;

    ai_rd_dispatcher dut (
        .ACLK_i(clk), .ARESETn_i(rst_n),
        .m_ARID_i(m_arid), .m_ARADDR_i(m_araddr), .m_ARBURST_i(m_arburst),
        .m_ARLEN_i(m_arlen), .m_ARSIZE_i(m_arsize), .m_ARVALID_i(m_arvalid),
        .m_ARREADY_o(m_arready), .m_RREADY_i(m_rready), .m_RID_o(m_rid),
        .m_RDATA_o(m_rdata), .m_RLAST_o(m_rlast), .m_RVALID_o(m_rvalid),
        .sa_ARID_o(sa_arid), .sa_ARADDR_o(sa_araddr), .sa_ARBURST_o(sa_arburst),
        .sa_ARLEN_o(sa_arlen), .sa_ARSIZE_o(sa_arsize), .sa_ARVALID_o(sa_arvalid),
        .sa_ARREADY_i(sa_arready), .sa_AR_outst_full_o(sa_full),
        .sa_RID_i(sa_rid), .sa_RDATA_i(sa_rdata), .sa_RLAST_i(sa_rlast),
        .sa_RVALID_i(sa_rvalid), .sa_RREADY_o(sa_rready)
    );

    function automatic int exp_sel(logic [AW-1:0] a);
        int raw;
        raw = int'((a >> LSB) & ((1 << (MSB - LSB + 1)) - 1));
        return (raw >= SLV) ? SLV - 1 : raw;
    endfunction

    // Advance one clock and update the order model from the spec's handshake rules.
    task automatic step();
        int  s;
        int  sel;
        bit  do_push;
        bit  do_pop;
        s = oq.size();
        sel = exp_sel(m_araddr);
        do_push = m_arvalid && (s < OUTST) && sa_arready[sel];
        do_pop  = (s > 0) && m_rready && sa_rvalid[oq[0]] && sa_rlast[oq[0]];
        @(posedge clk);
        #1;
        if (do_pop) void'(oq.pop_front());
        if (do_push) oq.push_back(sel);
    endtask

    task automatic new_ar(logic [AW-1:0] addr, logic [7:0] len);
        m_arvalid = 1'b1;
        m_araddr  = addr;
        m_arlen   = len;
        m_arid    = IDW'($urandom);
        m_arburst = 2'b01;
        m_arsize  = 3'd2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        new_ar(32'h0000_0010, 8'd0);
        sa_arready = '1;
        sa_rvalid  = '1;
        sa_rlast   = '1;
        m_rready   = 1'b1;
        sa_rdata   = '0;
        sa_rid     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (m_arready !== 1'b0) begin n_err++; $display("FAIL reset_arready got %b exp 0", m_arready); end
        n_cmp++; if (sa_arvalid !== 2'b00) begin n_err++; $display("FAIL reset_sa_arvalid got %b exp 00", sa_arvalid); end
        n_cmp++; if (m_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b exp 0", m_rvalid); end
        n_cmp++; if (sa_rready !== 2'b00) begin n_err++; $display("FAIL reset_sa_rready got %b exp 00", sa_rready); end
        m_arvalid = 1'b0;
        rst_n = 1'b1;
        oq.delete();
        #2;
        n_cmp++; if (sa_full !== 2'b00) begin n_err++; $display("FAIL post_reset_full got %b exp 00", sa_full); end
        n_cmp++; if (m_rvalid !== 1'b0) begin n_err++; $display("FAIL post_reset_rvalid got %b exp 0", m_rvalid); end
        n_cmp++; if (sa_rready !== 2'b00) begin n_err++; $display("FAIL post_reset_sa_rready got %b exp 00", sa_rready); end
        sa_rvalid = '0;
        sa_rlast  = '0;
        m_rready  = 1'b0;
        step();
    endtask

    task automatic test_ar_decode();
        sa_arready = '1;
        new_ar(32'h0000_0010, 8'd3);
        #2;
        n_cmp++; if (sa_arvalid !== 2'b01) begin n_err++; $display("FAIL ar0_sa_arvalid got %b exp 01", sa_arvalid); end
        n_cmp++; if (m_arready !== 1'b1) begin n_err++; $display("FAIL ar0_arready got %b exp 1", m_arready); end
        n_cmp++; if (sa_arlen !== {SLV{8'd3}}) begin n_err++; $display("FAIL ar0_arlen got %h exp %h", sa_arlen, {SLV{8'd3}}); end
        n_cmp++; if (sa_araddr !== {SLV{m_araddr}}) begin n_err++; $display("FAIL ar0_araddr got %h exp %h", sa_araddr, {SLV{m_araddr}}); end
        n_cmp++; if (sa_arid !== {SLV{m_arid}}) begin n_err++; $display("FAIL ar0_arid got %h exp %h", sa_arid, {SLV{m_arid}}); end
        step();
        new_ar(32'h4000_0010, 8'd0);
        #2;
        n_cmp++; if (sa_arvalid !== 2'b10) begin n_err++; $display("FAIL ar1_sa_arvalid got %b exp 10", sa_arvalid); end
        n_cmp++; if (m_arready !== 1'b1) begin n_err++; $display("FAIL ar1_arready got %b exp 1", m_arready); end
        step();
        m_arvalid = 1'b0;
        #2;
        n_cmp++; if (sa_arvalid !== 2'b00) begin n_err++; $display("FAIL ar_idle_sa_arvalid got %b exp 00", sa_arvalid); end
        step();
    endtask

    task automatic test_r_order();
        logic [DW-1:0] exp_d;
        sa_rvalid = 2'b10;
        sa_rlast  = 2'b10;
        sa_rdata  = {32'hBBBB_0001, 32'h0};
        sa_rid    = {5'd7, 5'd0};
        m_rready  = 1'b1;
        #2;
        n_cmp++; if (sa_rready !== 2'b01) begin n_err++; $display("FAIL order_stall_sa_rready got %b exp 01", sa_rready); end
        n_cmp++; if (m_rvalid !== 1'b0) begin n_err++; $display("FAIL order_stall_rvalid got %b exp 0", m_rvalid); end
        step();
        for (int b = 0; b < 4; b++) begin
            exp_d = 32'hA000_0000 + DW'(b);
            sa_rvalid = 2'b11;
            sa_rlast  = {1'b1, (b == 3)};
            sa_rdata  = {32'hBBBB_0001, exp_d};
            sa_rid    = {5'd7, 5'd5};
            #2;
            n_cmp++; if (m_rvalid !== 1'b1) begin n_err++; $display("FAIL s0_beat%0d_rvalid got %b exp 1", b, m_rvalid); end
            n_cmp++; if (m_rdata !== exp_d) begin n_err++; $display("FAIL s0_beat%0d_rdata got %h exp %h", b, m_rdata, exp_d); end
            n_cmp++; if (m_rlast !== (b == 3)) begin n_err++; $display("FAIL s0_beat%0d_rlast got %b exp %b", b, m_rlast, (b == 3)); end
            n_cmp++; if (sa_rready !== 2'b01) begin n_err++; $display("FAIL s0_beat%0d_sa_rready got %b exp 01", b, sa_rready); end
            step();
        end
        sa_rvalid = 2'b10;
        sa_rlast  = 2'b10;
        #2;
        n_cmp++; if (m_rdata !== 32'hBBBB_0001) begin n_err++; $display("FAIL s1_rdata got %h exp BBBB0001", m_rdata); end
        n_cmp++; if (m_rid !== 5'd7) begin n_err++; $display("FAIL s1_rid got %0d exp 7", m_rid); end
        n_cmp++; if (sa_rready !== 2'b10) begin n_err++; $display("FAIL s1_sa_rready got %b exp 10", sa_rready); end
        step();
        sa_rvalid = 2'b11;
        #2;
        n_cmp++; if (m_rvalid !== 1'b0) begin n_err++; $display("FAIL order_empty_rvalid got %b exp 0", m_rvalid); end
        n_cmp++; if (sa_rready !== 2'b00) begin n_err++; $display("FAIL order_empty_sa_rready got %b exp 00", sa_rready); end
        sa_rvalid = '0;
        sa_rlast  = '0;
        m_rready  = 1'b0;
        step();
    endtask

    task automatic drain_all(string tag);
        int h;
        logic [DW-1:0] d;
        for (int k = 0; k < OUTST + 2 && oq.size() > 0; k++) begin
            h = oq[0];
            d = DW'($urandom);
            sa_rdata  = {SLV{d ^ DW'(h)}};
            sa_rdata[h*DW +: DW] = d;
            sa_rvalid = '1;
            sa_rlast  = SLV'(1 << h);
            m_rready  = 1'b1;
            #2;
            n_cmp++; if (sa_rready !== SLV'(1 << h)) begin n_err++; $display("FAIL %s_drain%0d_sa_rready got %b exp %b", tag, k, sa_rready, SLV'(1 << h)); end
            n_cmp++; if (m_rdata !== d) begin n_err++; $display("FAIL %s_drain%0d_rdata got %h exp %h", tag, k, m_rdata, d); end
            step();
        end
        sa_rvalid = '0;
        sa_rlast  = '0;
        m_rready  = 1'b0;
    endtask

    task automatic test_full();
        int h;
        sa_arready = '1;
        sa_rvalid  = '0;
        m_rready   = 1'b0;
        for (int i = 0; i < OUTST; i++) begin
            new_ar({1'b0, 1'($urandom), 30'($urandom)}, 8'($urandom));
            #2;
            n_cmp++; if (m_arready !== 1'b1) begin n_err++; $display("FAIL fill%0d_arready got %b exp 1", i, m_arready); end
            step();
        end
        #2;
        n_cmp++; if (sa_full !== 2'b11) begin n_err++; $display("FAIL full_flag got %b exp 11", sa_full); end
        n_cmp++; if (m_arready !== 1'b0) begin n_err++; $display("FAIL full_arready got %b exp 0", m_arready); end
        n_cmp++; if (sa_arvalid !== 2'b00) begin n_err++; $display("FAIL full_sa_arvalid got %b exp 00", sa_arvalid); end
        step();
        h = oq[0];
        sa_rvalid = SLV'(1 << h);
        sa_rlast  = SLV'(1 << h);
        m_rready  = 1'b1;
        #2;
        n_cmp++; if (m_rvalid !== 1'b1) begin n_err++; $display("FAIL full_pop_rvalid got %b exp 1", m_rvalid); end
        n_cmp++; if (m_arready !== 1'b0) begin n_err++; $display("FAIL full_nobypass_arready got %b exp 0", m_arready); end
        step();
        sa_rvalid = '0;
        sa_rlast  = '0;
        m_rready  = 1'b0;
        #2;
        n_cmp++; if (m_arready !== 1'b1) begin n_err++; $display("FAIL after_pop_arready got %b exp 1", m_arready); end
        n_cmp++; if (sa_full !== 2'b00) begin n_err++; $display("FAIL after_pop_full got %b exp 00", sa_full); end
        step();
        m_arvalid = 1'b0;
        drain_all("full");
    endtask

    task automatic test_push_pop_same();
        int h;
        sa_arready = '1;
        for (int i = 0; i < 3; i++) begin
            new_ar({1'b0, 1'($urandom), 30'($urandom)}, 8'd0);
            step();
        end
        new_ar(32'h4000_0100, 8'd0);
        h = oq[0];
        sa_rvalid = SLV'(1 << h);
        sa_rlast  = SLV'(1 << h);
        m_rready  = 1'b1;
        #2;
        n_cmp++; if (m_arready !== 1'b1) begin n_err++; $display("FAIL same_arready got %b exp 1", m_arready); end
        n_cmp++; if (m_rvalid !== 1'b1 || m_rlast !== 1'b1) begin n_err++; $display("FAIL same_rvalid_rlast got %b%b exp 11", m_rvalid, m_rlast); end
        step();
        sa_rvalid = '0;
        sa_rlast  = '0;
        m_rready  = 1'b0;
        for (int i = 0; i < OUTST - 3; i++) begin
            new_ar({1'b0, 1'($urandom), 30'($urandom)}, 8'd0);
            #2;
            n_cmp++; if (sa_full !== 2'b00) begin n_err++; $display("FAIL same_refill%0d_full got %b exp 00", i, sa_full); end
            step();
        end
        m_arvalid = 1'b0;
        #2;
        n_cmp++; if (sa_full !== 2'b11) begin n_err++; $display("FAIL same_cnt_full got %b exp 11", sa_full); end
        drain_all("wrap");
    endtask

    task automatic test_random();
        int h;
        int sel;
        bit full_e;
        logic [SLV-1:0] e_arvalid;
        logic [SLV-1:0] e_rready;
        logic e_arready;
        logic e_rvalid;
        for (int c = 0; c < 400; c++) begin
            m_arvalid  = 1'($urandom);
            m_araddr   = AW'($urandom);
            m_arid     = IDW'($urandom);
            m_arlen    = 8'($urandom);
            m_arburst  = 2'($urandom);
            m_arsize   = 3'($urandom);
            sa_arready = SLV'($urandom);
            sa_rvalid  = SLV'($urandom);
            sa_rlast   = SLV'(($urandom_range(0, 2) == 0) ? 2'b11 : SLV'($urandom));
            sa_rdata   = {32'($urandom), 32'($urandom)};
            sa_rid     = SLV*IDW'($urandom);
            m_rready   = ($urandom_range(0, 3) != 0);
            #2;
            sel = exp_sel(m_araddr);
            full_e = (oq.size() == OUTST);
            e_arready = !full_e && sa_arready[sel];
            e_arvalid = (m_arvalid && !full_e) ? SLV'(1 << sel) : '0;
            if (oq.size() > 0) begin
                h = oq[0];
                e_rvalid = sa_rvalid[h];
                e_rready = m_rready ? SLV'(1 << h) : '0;
            end else begin
                h = 0;
                e_rvalid = 1'b0;
                e_rready = '0;
            end
            n_cmp++; if (m_arready !== e_arready) begin n_err++; $display("FAIL rnd%0d_arready got %b exp %b", c, m_arready, e_arready); end
            n_cmp++; if (sa_arvalid !== e_arvalid) begin n_err++; $display("FAIL rnd%0d_sa_arvalid got %b exp %b", c, sa_arvalid, e_arvalid); end
            n_cmp++; if (sa_full !== {SLV{full_e}}) begin n_err++; $display("FAIL rnd%0d_full got %b exp %b", c, sa_full, {SLV{full_e}}); end
            n_cmp++; if (m_rvalid !== e_rvalid) begin n_err++; $display("FAIL rnd%0d_rvalid got %b exp %b", c, m_rvalid, e_rvalid); end
            n_cmp++; if (sa_rready !== e_rready) begin n_err++; $display("FAIL rnd%0d_sa_rready got %b exp %b", c, sa_rready, e_rready); end
            if (e_rvalid) begin
                n_cmp++; if (m_rdata !== sa_rdata[h*DW +: DW]) begin n_err++; $display("FAIL rnd%0d_rdata got %h exp %h", c, m_rdata, sa_rdata[h*DW +: DW]); end
                n_cmp++; if (m_rid !== sa_rid[h*IDW +: IDW]) begin n_err++; $display("FAIL rnd%0d_rid got %h exp %h", c, m_rid, sa_rid[h*IDW +: IDW]); end
                n_cmp++; if (m_rlast !== sa_rlast[h]) begin n_err++; $display("FAIL rnd%0d_rlast got %b exp %b", c, m_rlast, sa_rlast[h]); end
            end
            step();
        end
        m_arvalid = 1'b0;
        drain_all("rnd");
    endtask

    initial begin
        test_reset();
        test_ar_decode();
        test_r_order();
        test_full();
        test_push_pop_same();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
